// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } hz_state_e;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 255;

  // Control bundle, MSB first:
  // stall_pc, stall_if_id, bubble_id_ex, flush_if_id, flush_id_ex, freeze.
  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic bubble_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
    logic freeze;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_IDLE       = hz_ctrl_t'(6'b000000);
  localparam hz_ctrl_t CTRL_MEM_STALL  = hz_ctrl_t'(6'b110001);
  localparam hz_ctrl_t CTRL_FLUSH      = hz_ctrl_t'(6'b000110);
  localparam hz_ctrl_t CTRL_NOP_BUBBLE = hz_ctrl_t'(6'b111000);

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_value;

  // Count up on inc, never wrapping past the maximum; clr wins over inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= '0;
    end else if (inc && (r_value != {WIDTH{1'b1}})) begin
      r_value <= r_value + WIDTH'(1);
    end
  end

  assign value = r_value;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: data-memory stall, branch flush and
// load-use bubble, with a stall-cycle counter and a memory timeout flag.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic [4:0]       Rd_ID_EX,
  input  logic             memRead_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_ME,
  input  logic             dmem_ready,
  output logic             stall_PC,
  output logic             stall_IF_ID,
  output logic             bubble_ID_EX,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             freeze_EX_ME_WB,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  // Wide enough to hold TIMEOUT, so saturation never hides the threshold.
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  hz_state_e         r_state;
  hz_state_e         w_next;
  hz_ctrl_t          w_ctrl;
  logic              w_ms;
  logic              w_lu;
  logic              w_wait_clr;
  logic              w_wait_inc;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic              r_timeout;

  // The ready cycle itself is never frozen, even while still in MEM_WAIT.
  assign w_ms = ((r_state == MEM_WAIT) || (dmem_req_ME && !dmem_ready)) && !dmem_ready;
  assign w_lu = memRead_ID_EX && (Rd_ID_EX != 5'd0) &&
                ((Rd_ID_EX == Rs1_ID) || (Rd_ID_EX == Rs2_ID));

  // State register; reset aborts any outstanding memory wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and prioritised controls: memory stall > branch flush > load-use.
  always_comb begin
    w_next = RUN;
    w_ctrl = CTRL_IDLE;
    case (r_state)
      RUN:      w_next = (dmem_req_ME && !dmem_ready) ? MEM_WAIT : RUN;
      MEM_WAIT: w_next = dmem_ready ? RUN : MEM_WAIT;
      default:  w_next = RUN;
    endcase
    if (w_ms) begin
      w_ctrl = CTRL_MEM_STALL;
    end else if (branch_taken_EX) begin
      // A load-use pair behind a taken branch is on the wrong path.
      w_ctrl = CTRL_FLUSH;
    end else if (w_lu) begin
      w_ctrl = CTRL_NOP_BUBBLE;
    end
    if (rst) begin
      w_ctrl = CTRL_IDLE;
    end
  end

  assign stall_PC        = w_ctrl.stall_pc;
  assign stall_IF_ID     = w_ctrl.stall_if_id;
  assign bubble_ID_EX    = w_ctrl.bubble_id_ex;
  assign flush_IF_ID     = w_ctrl.flush_if_id;
  assign flush_ID_EX     = w_ctrl.flush_id_ex;
  assign freeze_EX_ME_WB = w_ctrl.freeze;
  assign state           = r_state;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (w_ctrl.stall_pc),
    .value (stall_cycles)
  );

  // Wait counter restarts on each entry into MEM_WAIT and counts its cycles.
  assign w_wait_clr = (r_state != MEM_WAIT) && (w_next == MEM_WAIT);
  assign w_wait_inc = (r_state == MEM_WAIT);

  sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_wait_clr),
    .inc   (w_wait_inc),
    .value (w_wait_cnt)
  );

  // Sticky timeout: set on the edge where the wait count reaches TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= 1'b0;
    end else if (w_wait_inc && (w_wait_cnt >= WAIT_LAST)) begin
      r_timeout <= 1'b1;
    end
  end

  assign mem_timeout = r_timeout;

endmodule
